// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI control-register front end: register map,
// frame length and the frame FSM state encoding.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [6:0] REG_MUX_SEL = 7'h00;
  localparam logic [6:0] REG_LED     = 7'h01;
  localparam logic [6:0] REG_ERR_CNT = 7'h02;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR    = 2'd1,
    ST_DATA    = 2'd2,
    ST_OVERRUN = 2'd3
  } state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-stage synchroniser for one async SPI pin, plus an edge-detect flop
// producing single-clk rise/fall pulses in the clk domain.
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI slave + control-register bank, sampled entirely in the clk domain.
// Optional MISO readback is built when SPI_REG_READBACK_EN is defined.
//
// state      | meaning
// ST_IDLE    | CS high, waiting for a frame
// ST_ADDR    | shifting R/nW + 7-bit address (first 8 bits)
// ST_DATA    | shifting the 8 data bits
// ST_OVERRUN | more than FRAME_BITS clocks seen; wait for CS release
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = spi_reg_pkg::FRAME_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] mux_sel,
  output logic [1:0] led,
  output logic       wr_strobe,
  output logic       frame_err
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS);
  localparam logic [4:0] HDR_BIT  = 5'd7;

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(spi_sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));

  // CS idles high, so its chain resets high to avoid a false release edge
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(spi_cs),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(spi_mosi),
    .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

  state_t      state, state_nx;
  logic [4:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        hdr_rw;
  logic [6:0]  hdr_addr;
  logic [7:0]  err_cnt;

  logic start, shift, latch_hdr, commit, err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // CS release has priority; a coincident SCLK edge is dropped
  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    shift     = 1'b0;
    latch_hdr = 1'b0;
    commit    = 1'b0;
    err       = 1'b0;
    if (cs_rise) begin
      state_nx = ST_IDLE;
      if (state == ST_DATA && bit_cnt == LAST_BIT) begin
        if (hdr_rw)
          err = (hdr_addr > REG_ERR_CNT);
        else if (hdr_addr == REG_MUX_SEL || hdr_addr == REG_LED)
          commit = 1'b1;
        else
          err = (hdr_addr != REG_ERR_CNT);
      end else begin
        err = 1'b1;
      end
    end else if (cs_fall) begin
      state_nx = ST_ADDR;
      start    = 1'b1;
    end else if (sclk_fall) begin
      case (state)
        ST_ADDR: begin
          shift = 1'b1;
          if (bit_cnt == HDR_BIT) begin
            latch_hdr = 1'b1;
            state_nx  = ST_DATA;
          end
        end
        ST_DATA: begin
          shift = 1'b1;
          if (bit_cnt == LAST_BIT) state_nx = ST_OVERRUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      hdr_rw    <= 1'b0;
      hdr_addr  <= '0;
      mux_sel   <= '0;
      led       <= '0;
      err_cnt   <= '0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (start) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (shift) begin
        shreg <= {shreg[6:0], mosi_s};
        if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
      end
      if (latch_hdr) begin
        hdr_rw   <= shreg[6];
        hdr_addr <= {shreg[5:0], mosi_s};
      end
      if (commit) begin
        if (hdr_addr == REG_MUX_SEL) mux_sel <= shreg;
        else                         led     <= shreg[1:0];
        wr_strobe <= 1'b1;
      end
      if (err) begin
        frame_err <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

`ifdef SPI_REG_READBACK_EN
  logic [7:0] miso_sr;
  logic [7:0] rd_val;
  logic [6:0] rd_addr;

  // Header is being latched this clk, so decode the address from the shifter
  assign rd_addr = {shreg[5:0], mosi_s};

  always_comb begin
    rd_val = 8'h00;
    case (rd_addr)
      REG_MUX_SEL: rd_val = mux_sel;
      REG_LED:     rd_val = {6'b0, led};
      REG_ERR_CNT: rd_val = err_cnt;
      default:     rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_sr  <= '0;
      spi_miso <= 1'b0;
    end else begin
      if (latch_hdr)
        miso_sr <= shreg[6] ? rd_val : 8'h00;
      else if (sclk_rise && state == ST_DATA)
        miso_sr <= {miso_sr[6:0], 1'b0};
      if (cs_rise)
        spi_miso <= 1'b0;
      else if (sclk_rise)
        spi_miso <= (state == ST_DATA) ? miso_sr[7] : 1'b0;
    end
  end

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};
`else
  assign spi_miso = 1'b0;

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, sclk_rise, cs_lvl, mosi_rise, mosi_fall};
`endif

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed frames plus random frames
// compared against a register-map level model of the host protocol.
module tb_spi_reg_ctrl;

  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [7:0] mux_sel;
  logic [1:0] led;
  logic       wr_strobe;
  logic       frame_err;

  int n_chk = 0;
  int n_fail = 0;
  int n_wr = 0;
  int n_ferr = 0;

  logic [7:0] m_mux = 8'h00;
  logic [1:0] m_led = 2'b00;
  logic [7:0] m_err = 8'h00;
  int         m_wr = 0;
  int         m_ferr = 0;

  always #42 clk = ~clk;

  spi_reg_ctrl #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs(spi_cs),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .mux_sel(mux_sel),
    .led(led), .wr_strobe(wr_strobe), .frame_err(frame_err));

  always @(negedge clk) begin
    if (wr_strobe) n_wr++;
    if (frame_err) n_ferr++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Protocol-level model: what a 16-bit frame means for the register map
  task automatic model_frame(input logic [31:0] bits, input int nbits, output logic [7:0] exp_miso);
    logic       rw;
    logic [6:0] a;
    logic [7:0] d;
    logic       ok;
    exp_miso = 8'h00;
    ok = 1'b0;
    if (nbits == 16) begin
      rw = bits[15];
      a  = bits[14:8];
      d  = bits[7:0];
      if (rw) begin
        ok = (a <= 7'd2);
`ifdef SPI_REG_READBACK_EN
        if (a == 7'd0)      exp_miso = m_mux;
        else if (a == 7'd1) exp_miso = {6'b0, m_led};
        else if (a == 7'd2) exp_miso = m_err;
`endif
      end else if (a == 7'd0) begin
        m_mux = d; m_wr++; ok = 1'b1;
      end else if (a == 7'd1) begin
        m_led = d[1:0]; m_wr++; ok = 1'b1;
      end else if (a == 7'd2) begin
        ok = 1'b1;
      end
    end
    if (!ok) begin
      m_ferr++;
      if (m_err < 8'hFF) m_err = m_err + 8'd1;
    end
  endtask

  task automatic frame_begin();
    wait_clk(4);
    spi_cs = 1'b0;
    wait_clk(6);
  endtask

  task automatic send_bit(input logic b, output logic m);
    spi_mosi = b;
    wait_clk(3);
    spi_sclk = 1'b1;
    wait_clk(6);
    m = spi_miso;
    spi_sclk = 1'b0;
    wait_clk(3);
  endtask

  task automatic frame_end();
    wait_clk(3);
    spi_cs = 1'b1;
    wait_clk(SYNC_STAGES + 2);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".mux"}, 32'(mux_sel), 32'(m_mux));
    chk({tag, ".led"}, 32'(led), 32'(m_led));
    chk({tag, ".err_cnt"}, 32'(dut.err_cnt), 32'(m_err));
    chk({tag, ".wr_cnt"}, n_wr, m_wr);
    chk({tag, ".ferr_cnt"}, n_ferr, m_ferr);
  endtask

  task automatic run_frame(input logic [31:0] bits, input int nbits, input string tag);
    logic [7:0] exp_m;
    logic [7:0] got_m;
    logic       m;
    got_m = 8'h00;
    model_frame(bits, nbits, exp_m);
    frame_begin();
    for (int i = 0; i < nbits; i++) begin
      send_bit(bits[nbits-1-i], m);
      if (i >= 8 && i < 16) got_m = {got_m[6:0], m};
    end
    frame_end();
    check_state(tag);
    if (nbits == 16) chk({tag, ".miso"}, 32'(got_m), 32'(exp_m));
  endtask

  initial begin
    logic [31:0] bits;
    int          nbits;
    logic        m;
    logic [7:0]  dummy;

    wait_clk(3);
    chk("rst.mux", 32'(mux_sel), 0);
    chk("rst.led", 32'(led), 0);
    chk("rst.wr_strobe", 32'(wr_strobe), 0);
    chk("rst.frame_err", 32'(frame_err), 0);
    chk("rst.miso", 32'(spi_miso), 0);
    chk("rst.err_cnt", 32'(dut.err_cnt), 0);
    rst_n = 1'b1;
    wait_clk(3);

    run_frame(32'h0102, 16, "wr_led");
    run_frame(32'h0001, 16, "wr_mux");
    run_frame(32'h001, 12, "short12");
    run_frame(32'hABCDE, 20, "over20");
    run_frame(32'h8200, 16, "rd_err");
    run_frame(32'h0103, 16, "wr_led3");
    run_frame(32'h8100, 16, "rd_led");
    run_frame(32'h0255, 16, "wr_ro");
    run_frame(32'h8500, 16, "rd_unmapped");

    // Abort a write to mux_sel with a reset after 9 bits
    frame_begin();
    bits = 32'h00FF;
    for (int i = 0; i < 9; i++) send_bit(bits[15-i], m);
    rst_n = 1'b0;
    #1;
    chk("midrst.mux", 32'(mux_sel), 0);
    chk("midrst.led", 32'(led), 0);
    m_mux = 8'h00; m_led = 2'b00; m_err = 8'h00;
    spi_cs = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(8);
    check_state("midrst");
    run_frame(32'h00A5, 16, "post_rst");

    for (int k = 0; k < 40; k++) begin
      nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24)) : 16;
      bits = $urandom;
      if (nbits == 16) bits[14:8] = 7'($urandom_range(0, 4));
      run_frame(bits, nbits, $sformatf("rnd%0d", k));
    end

    for (int k = 0; k < 256; k++) begin
      model_frame(32'h0, 0, dummy);
      frame_begin();
      frame_end();
    end
    check_state("zero_len");
    chk("zero_len.sat", 32'(dut.err_cnt), 32'hFF);
    run_frame(32'h8200, 16, "rd_sat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
